boa_mem_sram_resp: RTL and testbench
====================================

BOA_MEM_SRAM_RESP -- requirements
Module: boa_mem_sram_resp

Interface
REQ-001 SHALL have parameter alen, default 32, address bus width (at least 8).
REQ-002 SHALL have parameter dlen, default 32, data bus width (32 or 64); wes = dlen/8 byte write enables.
REQ-003 SHALL have parameter depth_log2, default 10, RAM size in words (2**depth_log2).
REQ-004 SHALL have parameter base, default 32'h0000_1000, byte base address of the window; naturally aligned to the window size.
REQ-005 SHALL have parameter waits, default 0, wait-state count (0..15).
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port bus, boa_mem_bus.MEM modport, alen/dlen: re, we[wes-1:0], addr[alen-1:2] and wdata in; ready and rdata out.
REQ-009 SHALL have port busy, output, 1, high while in WAIT.

Function
REQ-010 SHALL decode the request: req = re || (we != 0); sel = req && base[alen-1:2] <= addr < base[alen-1:2] + 2**depth_log2; word index = addr - base[alen-1:2].
REQ-011 SHALL implement states IDLE, WAIT and RESP, with a 4-bit wait counter.
REQ-012 SHALL accept a request in a cycle where state is IDLE or RESP and sel = 1.
REQ-013 SHALL NOT accept a request in WAIT; inputs are ignored there because the initiator holds them stable.
REQ-014 SHALL, on acceptance, perform the write and capture the read at the closing clock edge.
REQ-015 SHALL, on that edge, write wdata byte i only where we[i] = 1.
REQ-016 SHALL, on that edge, load the read-data register with the RAM word as it was before that edge's write (read-before-write when re and we are both set).
REQ-017 SHALL, on acceptance with waits = 0, go to RESP; with waits > 0, go to WAIT with counter = waits.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the cycle the counter equals 1; ready is therefore 0 for exactly waits cycles.
REQ-019 SHALL, in RESP, re-enter RESP or WAIT when a new request is accepted that cycle (back-to-back), else go to IDLE.
REQ-020 SHALL drive ready = 0 in WAIT and ready = 1 in IDLE and RESP; ready is never 0 for an unselected or absent request.
REQ-021 SHALL drive rdata = captured read data in a RESP cycle whose accepted request had re = 1, else 0.
REQ-022 SHALL give a response latency of 1 + waits cycles: request in cycle N gives ready = 1 in cycle N+1+waits.
REQ-023 SHALL ignore unselected requests: no RAM change, no state change, ready = 1, rdata = 0.
REQ-024 SHALL ignore requests whose address is outside the window at both the low and high boundary; no index wrap-around.
REQ-025 SHALL drive busy = 1 exactly when state = WAIT.

Reset
REQ-026 SHALL, while rst = 0, immediately (asynchronously) force state IDLE, counter 0, read-data register 0, ready = 1, rdata = 0 and busy = 0.
REQ-027 SHALL abort any request in WAIT or RESP when rst asserts; a write not yet committed at an edge is not committed.
REQ-028 SHALL NOT reset RAM contents.
REQ-029 SHALL accept requests from the first rising edge after rst deasserts.

Verification
REQ-030 SHALL cover (waits = 0): write addr 0x1004>>2, we = 4'hF, wdata 0xDEADBEEF in cycle N, then read the same address in N+1 -> ready = 1 in N+1 and N+2; rdata = 0 in N+1 and 0xDEADBEEF in N+2.
REQ-031 SHALL cover a byte-lane write: word holding 0xDEADBEEF, write we = 4'b0010, wdata 0x0000AA00, then read -> rdata 0xDEADAAEF.
REQ-032 SHALL cover (waits = 3): read in cycle N with inputs held -> ready = 0 and busy = 1 in N+1..N+3; ready = 1 with data in N+4; busy = 0 in N+4.
REQ-033 SHALL cover window boundaries: writes to byte addresses 0x0FFC and 0x1000 + 4*2**depth_log2 -> ready stays 1, rdata 0, RAM unchanged.
REQ-034 SHALL cover (waits = 0): reads of words 0 and 1 in consecutive cycles -> ready = 1 in both response cycles with the correct data in order.
REQ-035 SHALL cover reset mid-wait: rst = 0 in the second WAIT cycle -> ready = 1, busy = 0 and rdata = 0 with no clock edge needed; after release, a read is served normally and RAM contents are preserved.

Source files
------------

// File: rtl/boa_mem_sram_resp_if.sv
// boa_mem_bus: simple synchronous memory bus.
//   re     - read request
//   we     - per-byte write enables (dlen/8 lanes)
//   addr   - word address (byte address bits [alen-1:2])
//   wdata  - write data
//   ready  - memory can complete / has completed the transfer this cycle
//   rdata  - read data, valid in the response cycle of a read
interface boa_mem_bus #(
  parameter int unsigned alen = 32,
  parameter int unsigned dlen = 32
);
  localparam int unsigned wes = dlen / 8;

  logic            re;
  logic [wes-1:0]  we;
  logic [alen-1:2] addr;
  logic [dlen-1:0] wdata;
  logic            ready;
  logic [dlen-1:0] rdata;

  modport MEM (
    input  re, we, addr, wdata,
    output ready, rdata
  );

  modport CPU (
    output re, we, addr, wdata,
    input  ready, rdata
  );
endinterface

// File: rtl/boa_mem_sram_resp.sv
// boa_mem_sram_resp: single-ported SRAM slave on boa_mem_bus with a programmable
// number of wait states. Requests hitting the address window are accepted in IDLE
// or RESP, write/read happen at the accepting edge, and the response (ready = 1)
// appears 1 + waits cycles after the request.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - boa_mem_bus MEM modport (re, we, addr, wdata in; ready, rdata out)
//   busy - high while counting wait states
module boa_mem_sram_resp #(
  parameter int unsigned     alen       = 32,
  parameter int unsigned     dlen       = 32,
  parameter int unsigned     depth_log2 = 10,
  parameter logic [alen-1:0] base       = 'h1000,
  parameter int unsigned     waits      = 0
) (
  input  logic     clk,
  input  logic     rst,
  boa_mem_bus.MEM  bus,
  output logic     busy
);

  localparam int unsigned     wes    = dlen / 8;
  localparam int unsigned     depth  = 2 ** depth_log2;
  localparam logic [alen-3:0] base_w = base[alen-1:2];
  localparam logic [3:0]      waits_l = 4'(waits);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]            r_state, w_state_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic [dlen-1:0]       r_rdata;
  logic                  r_rd_en;
  logic [dlen-1:0]       r_mem [depth];

  logic                  w_req;
  logic                  w_sel;
  logic                  w_accept;
  logic [alen-3:0]       w_off;
  logic [depth_log2-1:0] w_idx;

  // Window decode: offset is only meaningful when addr >= base, so the
  // subtraction never wraps into the window from below.
  always_comb begin
    w_req    = bus.re | (|bus.we);
    w_off    = bus.addr - base_w;
    w_sel    = w_req && (bus.addr >= base_w) && ((w_off >> depth_log2) == '0);
    w_idx    = w_off[depth_log2-1:0];
    w_accept = w_sel && (r_state != StWait);
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      StWait: begin
        if (r_cnt == 4'd1) begin
          w_state_next = StResp;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: begin
        if (w_accept) begin
          if (waits_l == 4'd0) begin
            w_state_next = StResp;
          end else begin
            w_state_next = StWait;
            w_cnt_next   = waits_l;
          end
        end else begin
          w_state_next = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_rdata <= '0;
      r_rd_en <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        // Non-blocking read of the array gives the pre-write word.
        r_rdata <= r_mem[w_idx];
        r_rd_en <= bus.re;
      end
    end
  end

  // RAM is not reset; rst gates the write so nothing commits while held in reset.
  always_ff @(posedge clk) begin
    if (w_accept && rst) begin
      for (int i = 0; i < wes; i++) begin
        if (bus.we[i]) begin
          r_mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    bus.ready = (r_state != StWait);
    busy      = (r_state == StWait);
    bus.rdata = ((r_state == StResp) && r_rd_en) ? r_rdata : '0;
  end

endmodule

// File: tb/tb_boa_mem_sram_resp.sv
module tb_boa_mem_sram_resp;

  typedef struct {
    int          cyc;
    int          dut;
    logic        rdy;
    logic        bsy;
    logic [31:0] rd;
    string       nm;
  } exp_t;

  logic clk;
  logic rst;
  logic busy0, busy1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  boa_mem_bus #(.alen(32), .dlen(32)) bus0 ();
  boa_mem_bus #(.alen(32), .dlen(32)) bus1 ();

  boa_mem_sram_resp #(.alen(32), .dlen(32), .depth_log2(10), .base(32'h1000), .waits(0)) u_d0 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus0),
    .busy (busy0)
  );

  boa_mem_sram_resp #(.alen(32), .dlen(32), .depth_log2(10), .base(32'h1000), .waits(3)) u_d1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus1),
    .busy (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  // Scoreboard insert, kept ordered by cycle.
  task automatic push(int d, int c, logic rdy, logic bsy, logic [31:0] rd, string nm);
    exp_t e;
    int   i;
    e.cyc = c; e.dut = d; e.rdy = rdy; e.bsy = bsy; e.rd = rd; e.nm = nm;
    i = sb_q.size();
    while (i > 0 && sb_q[i-1].cyc > c) i--;
    sb_q.insert(i, e);
  endtask

  // Monitor: compares DUT outputs against every expectation due this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic        a_rdy, a_bsy;
    logic [31:0] a_rd;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_chk++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.nm, e.cyc, cyc);
      end else begin
        if (e.dut == 0) begin
          a_rdy = bus0.ready; a_bsy = busy0; a_rd = bus0.rdata;
        end else begin
          a_rdy = bus1.ready; a_bsy = busy1; a_rd = bus1.rdata;
        end
        if (a_rdy !== e.rdy || a_bsy !== e.bsy || a_rd !== e.rd) begin
          n_fail++;
          $display("FAIL %s dut%0d cyc %0d: got ready=%b busy=%b rdata=%h, want ready=%b busy=%b rdata=%h",
                   e.nm, e.dut, cyc, a_rdy, a_bsy, a_rd, e.rdy, e.bsy, e.rd);
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(int d, logic re, logic [3:0] we, logic [31:0] ba, logic [31:0] wd);
    if (d == 0) begin
      bus0.re = re; bus0.we = we; bus0.addr = ba[31:2]; bus0.wdata = wd;
    end else begin
      bus1.re = re; bus1.we = we; bus1.addr = ba[31:2]; bus1.wdata = wd;
    end
  endtask

  task automatic idle(int d);
    drv(d, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Issue one request, hold it through the wait states, queue its expected response.
  task automatic req(int d, logic re, logic [3:0] we, logic [31:0] ba, logic [31:0] wd,
                     logic [31:0] exp_rd, string nm);
    int w;
    w = (d == 0) ? 0 : 3;
    drv(d, re, we, ba, wd);
    for (int i = 1; i <= w; i++) push(d, cyc + i, 1'b0, 1'b1, 32'h0, {nm, "_wait"});
    push(d, cyc + w + 1, 1'b1, 1'b0, exp_rd, nm);
    repeat (w + 1) step();
  endtask

  initial begin
    rst = 1'b0;
    idle(0);
    idle(1);
    #3;
    chk("rst_ready0", 32'(bus0.ready), 32'd1);
    chk("rst_busy0",  32'(busy0),      32'd0);
    chk("rst_rdata0", bus0.rdata,      32'h0);
    chk("rst_ready1", 32'(bus1.ready), 32'd1);
    chk("rst_busy1",  32'(busy1),      32'd0);
    chk("rst_rdata1", bus1.rdata,      32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();

    // waits = 0: write then read, byte lane write
    push(0, cyc, 1'b1, 1'b0, 32'h0, "idle_before_wr");
    req(0, 1'b0, 4'hF,    32'h1004, 32'hDEADBEEF, 32'h0,        "wr_full");
    req(0, 1'b1, 4'h0,    32'h1004, 32'h0,        32'hDEADBEEF, "rd_after_wr");
    req(0, 1'b0, 4'b0010, 32'h1004, 32'h0000AA00, 32'h0,        "wr_lane");
    req(0, 1'b1, 4'h0,    32'h1004, 32'h0,        32'hDEADAAEF, "rd_lane");

    // window edges
    req(0, 1'b0, 4'hF, 32'h1000, 32'hA0A0A0A0, 32'h0, "wr_first");
    req(0, 1'b0, 4'hF, 32'h1FFC, 32'h0BADF00D, 32'h0, "wr_last");
    push(0, cyc, 1'b1, 1'b0, 32'h0, "oow_low_now");
    req(0, 1'b0, 4'hF, 32'h0FFC, 32'h11111111, 32'h0, "wr_oow_low");
    req(0, 1'b0, 4'hF, 32'h2000, 32'h22222222, 32'h0, "wr_oow_high");
    req(0, 1'b1, 4'h0, 32'h0FFC, 32'h0,        32'h0, "rd_oow_low");
    req(0, 1'b1, 4'h0, 32'h2000, 32'h0,        32'h0, "rd_oow_high");
    req(0, 1'b1, 4'h0, 32'h1000, 32'h0, 32'hA0A0A0A0, "rd_first");
    req(0, 1'b1, 4'h0, 32'h1FFC, 32'h0, 32'h0BADF00D, "rd_last");

    // consecutive reads, read-before-write
    req(0, 1'b0, 4'hF, 32'h1000, 32'h01234567, 32'h0, "wr_w0");
    req(0, 1'b0, 4'hF, 32'h1004, 32'h89ABCDEF, 32'h0, "wr_w1");
    req(0, 1'b1, 4'h0, 32'h1000, 32'h0, 32'h01234567, "b2b_rd_w0");
    req(0, 1'b1, 4'h0, 32'h1004, 32'h0, 32'h89ABCDEF, "b2b_rd_w1");
    req(0, 1'b1, 4'hF, 32'h1004, 32'h55555555, 32'h89ABCDEF, "rbw");
    req(0, 1'b1, 4'h0, 32'h1004, 32'h0, 32'h55555555, "rd_after_rbw");
    idle(0);
    push(0, cyc + 1, 1'b1, 1'b0, 32'h0, "d0_back_idle");
    step();

    // waits = 3
    req(1, 1'b0, 4'hF, 32'h1008, 32'hCAFEF00D, 32'h0, "ws_wr");
    req(1, 1'b1, 4'h0, 32'h1008, 32'h0, 32'hCAFEF00D, "ws_rd");
    idle(1);
    push(1, cyc + 1, 1'b1, 1'b0, 32'h0, "d1_back_idle");
    step();
    step();

    // reset in the second wait cycle
    drv(1, 1'b1, 4'h0, 32'h1008, 32'h0);
    push(1, cyc + 1, 1'b0, 1'b1, 32'h0, "pre_rst_wait");
    step();
    step();
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus1.ready), 32'd1);
    chk("midrst_busy",  32'(busy1),      32'd0);
    chk("midrst_rdata", bus1.rdata,      32'h0);
    drv(1, 1'b0, 4'hF, 32'h1008, 32'h0);
    step();
    step();
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    req(1, 1'b1, 4'h0, 32'h1008, 32'h0, 32'hCAFEF00D, "post_rst_rd");
    idle(1);
    req(0, 1'b1, 4'h0, 32'h1004, 32'h0, 32'h55555555, "post_rst_rd_d0");
    idle(0);
    repeat (3) step();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
